spi_slave_nbit: RTL and testbench
=================================

SPI_SLAVE_NBIT -- requirements
Module: spi_slave_nbit

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits (2..32).
REQ-002 Parameter CPOL, default 0, idle level of sclk.
REQ-003 Parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter SYNC_STAGES, default 2, synchroniser depth on sclk/ss/mosi (2..4).
REQ-005 clk  in  1  sole system clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 sclk  in  1  SPI clock, asynchronous to clk.
REQ-008 ss  in  1  slave select, active-low, asynchronous.
REQ-009 mosi  in  1  serial data in, MSB first.
REQ-010 miso  out  1  serial data out, MSB first.
REQ-011 data  out  WIDTH  last complete received word.
REQ-012 valid  out  1  one-cycle pulse: data updated this cycle.
REQ-013 sot  out  1  high with valid for the first word of a transfer only.
REQ-014 eot  out  1  one-cycle pulse on ss deassertion.
REQ-015 frag  out  1  one-cycle pulse with eot when the transfer ended mid-word.
REQ-016 tx_data  in  WIDTH  next word to transmit.
REQ-017 tx_ready  out  1  one-cycle pulse: tx_data captured this cycle.

Function
REQ-018 sclk, ss, mosi SHALL each pass through SYNC_STAGES flops; all logic uses synchronised copies only.
REQ-019 Sample edge SHALL be synchronised-sclk rising when CPOL==CPHA, else falling; the opposite edge is the shift edge.
REQ-020 Edges SHALL be detected by comparing synchronised sclk with its value one clk earlier; edges while ss inactive SHALL be ignored.
REQ-021 On each sample edge with ss active, rx shift register SHALL take {rx[WIDTH-2:0], mosi} and bit counter SHALL increment, wrapping WIDTH-1 -> 0.
REQ-022 When the counter wraps, data SHALL load the completed word and valid SHALL pulse the next clk cycle (latency 1 clk after the synchronised edge).
REQ-023 data SHALL hold its value until the next completed word; it is not cleared at end of transfer.
REQ-024 sot SHALL be high with the first valid after ss assertion, low for all later words.
REQ-025 On ss falling (synchronised), bit counter and rx register SHALL clear and, for CPHA=0, tx shift SHALL load tx_data with tx_ready pulse.
REQ-026 On each shift edge with ss active: if bit counter==0, tx shift SHALL load tx_data with tx_ready pulse; else tx shift SHALL shift left one bit.
REQ-027 miso SHALL equal tx shift MSB while ss active, 0 while ss inactive.
REQ-028 On ss rising (synchronised), eot SHALL pulse once; frag SHALL pulse with it if bit counter!=0; partial bits are discarded, no valid.
REQ-029 ss deassert and sample edge in the same cycle: the sample edge SHALL be ignored, eot/frag take priority.
REQ-030 A transfer of zero bits SHALL produce eot without frag, sot or valid.

Reset
REQ-031 While rst high: data=0, valid=0, sot=0, eot=0, frag=0, tx_ready=0, miso=0, counters/shift registers 0.
REQ-032 Synchroniser flops SHALL reset to idle: ss=1, sclk=CPOL, mosi=0; no edge or eot SHALL be detected in the first cycle after reset.
REQ-033 Reset asserted mid-transfer SHALL abort it silently; with ss still low after release, reception restarts at bit 0 on the next sample edge, sot on the first word.

Configuration
REQ-034 Macro SPI_SLAVE_NBIT_TX_EN defined: transmit path (tx shift, tx_ready, miso) per REQ-025..027.
REQ-035 Macro undefined: no tx logic; miso tied 0, tx_ready tied 0, tx_data unused; receive behaviour identical.

Verification
REQ-036 WIDTH=8, mode 0, send 0xA5 then 0x3C in one ss frame -> valid twice, data 0xA5 with sot=1, then 0x3C with sot=0, eot once at end, frag=0.
REQ-037 Mode 0, tx_data=0x96 before ss falls -> miso bits 1,0,0,1,0,1,1,0 at master sample edges, tx_ready pulse at ss fall and again at word boundary.
REQ-038 WIDTH=12, CPOL=1 CPHA=1, send 0xABC -> data 0xABC, valid once, sot=1.
REQ-039 Mode 0, send 5 bits then raise ss -> no valid, eot and frag pulse same cycle, data keeps previous value.
REQ-040 Assert rst after 4 bits of 0xFF, release with ss low, send 0x12 -> data 0x12, sot=1, no valid for the aborted word.
REQ-041 Build without SPI_SLAVE_NBIT_TX_EN, repeat REQ-036 -> identical rx results, miso and tx_ready constant 0.

Source files
------------

// File: rtl/spi_slave_nbit.sv
// ---------------------------------------------------------------------------
// spi_slave_nbit
//
// SPI slave with a configurable word length. It receives MSB-first words on
// mosi and presents each completed word on data with a one-cycle valid pulse.
// Optionally it transmits MSB-first words on miso, taken from tx_data.
// All logic runs on the single system clock clk. sclk, ss and mosi are
// asynchronous and are only used after a SYNC_STAGES-deep synchroniser.
//
// Parameters
//   WIDTH       word length in bits (2..32)
//   CPOL        idle level of sclk
//   CPHA        0: sample on the leading edge, 1: sample on the trailing edge
//   SYNC_STAGES synchroniser depth on sclk/ss/mosi (2..4)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   sclk      in   SPI clock (asynchronous)
//   ss        in   slave select, active low (asynchronous)
//   mosi      in   serial data in, MSB first
//   miso      out  serial data out, MSB first (0 while ss inactive)
//   data      out  last complete received word, held until the next one
//   valid     out  one-cycle pulse, data updated this cycle
//   sot       out  high with valid for the first word of a transfer
//   eot       out  one-cycle pulse when ss deasserts
//   frag      out  one-cycle pulse with eot if the transfer ended mid-word
//   tx_data   in   next word to transmit
//   tx_ready  out  one-cycle pulse, tx_data captured this cycle
//
// Build option
//   SPI_SLAVE_NBIT_TX_EN  define to build the transmit path. Without it miso
//                         and tx_ready are tied low and tx_data is ignored.
// ---------------------------------------------------------------------------
module spi_slave_nbit #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             sot,
  output logic             eot,
  output logic             frag,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready
);

  localparam int unsigned      CNT_W       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WIDTH - 1);
  localparam logic             SCLK_IDLE   = 1'(CPOL);
  localparam logic             SAMPLE_RISE = 1'(CPOL == CPHA);

  // Elaboration-time parameter range checks
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("spi_slave_nbit: WIDTH must be in 2..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("spi_slave_nbit: SYNC_STAGES must be in 2..4");
  end

  // Synchroniser chains, index 0 is the input-side flop
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  // One-cycle-delayed synchronised sclk/ss for edge detection
  logic sclk_prev_q, sclk_prev_d;
  logic ss_prev_q,   ss_prev_d;

  // Receive state
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-2:0] rx_q,    rx_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             valid_q, valid_d;
  logic             sot_q,   sot_d;
  logic             eot_q,   eot_d;
  logic             frag_q,  frag_d;
  logic             first_q, first_d;

  // Synchronised copies and derived events
  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic ss_active;
  logic sclk_rise;
  logic sclk_fall;
  logic sample_edge;
  logic ss_fall;
  logic ss_rise;

  // Working values inside the receive next-state logic
  logic [CNT_W-1:0] cnt_base;
  logic [WIDTH-2:0] rx_base;
  logic             first_base;
  logic [WIDTH-1:0] rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_active = ~ss_s;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;

  // Gated by ss_active: a sample edge coinciding with ss deassertion is
  // dropped automatically, so eot/frag win.
  assign sample_edge = ss_active & (SAMPLE_RISE ? sclk_rise : sclk_fall);

  // Synchroniser and receive registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= SCLK_IDLE;
      ss_prev_q   <= 1'b1;
      cnt_q       <= '0;
      rx_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sot_q       <= 1'b0;
      eot_q       <= 1'b0;
      frag_q      <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sot_q       <= sot_d;
      eot_q       <= eot_d;
      frag_q      <= frag_d;
      first_q     <= first_d;
    end
  end

  // Synchroniser shift and edge history
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
  end

  // Receive next-state: framing, bit counting and word completion
  always_comb begin
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    sot_d      = 1'b0;
    eot_d      = 1'b0;
    frag_d     = 1'b0;
    first_d    = first_q;
    cnt_base   = cnt_q;
    rx_base    = rx_q;
    first_base = first_q;
    rx_next    = {rx_q, mosi_s};

    if (ss_rise) begin
      // End of transfer: report it, drop any partial word
      eot_d   = 1'b1;
      frag_d  = (cnt_q != '0);
      cnt_d   = '0;
      rx_d    = '0;
      first_d = 1'b1;
    end else begin
      // Start of transfer: restart from bit 0, next word is the first one
      if (ss_fall) begin
        cnt_base   = '0;
        rx_base    = '0;
        first_base = 1'b1;
      end
      cnt_d   = cnt_base;
      rx_d    = rx_base;
      first_d = first_base;
      rx_next = {rx_base, mosi_s};

      if (sample_edge) begin
        rx_d = rx_next[WIDTH-2:0];
        if (cnt_base == CNT_LAST) begin
          cnt_d   = '0;
          data_d  = rx_next;
          valid_d = 1'b1;
          sot_d   = first_base;
          first_d = 1'b0;
        end else begin
          cnt_d = cnt_base + CNT_W'(1);
        end
      end
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign sot   = sot_q;
  assign eot   = eot_q;
  assign frag  = frag_q;

`ifdef SPI_SLAVE_NBIT_TX_EN
  // In CPHA=0 the first bit must be on miso before the first sclk edge, so
  // the word is loaded when ss falls; in CPHA=1 the leading edge loads it.
  localparam logic LOAD_ON_SS_FALL = 1'(CPHA == 0);

  logic             shift_edge;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic             tx_ready_q, tx_ready_d;
  logic             miso_q,     miso_d;

  assign shift_edge = ss_active & (SAMPLE_RISE ? sclk_fall : sclk_rise);

  // Transmit registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_q <= '0;
      tx_ready_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_ready_q <= tx_ready_d;
      miso_q     <= miso_d;
    end
  end

  // Transmit next-state: load at word boundaries, otherwise shift left
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_ready_d = 1'b0;
    if (ss_fall && LOAD_ON_SS_FALL) begin
      tx_shift_d = tx_data;
      tx_ready_d = 1'b1;
    end
    if (shift_edge) begin
      if (cnt_q == '0) begin
        tx_shift_d = tx_data;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
      end
    end
    miso_d = ss_active ? tx_shift_d[WIDTH-1] : 1'b0;
  end

  assign miso     = miso_q;
  assign tx_ready = tx_ready_q;
`else
  // Receive-only build
  logic unused_tx_data;

  assign unused_tx_data = ^tx_data;
  assign miso           = 1'b0;
  assign tx_ready       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_nbit.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_nbit
//
// Drives two instances: dut_a (WIDTH=8, mode 0) and dut_b (WIDTH=12, mode 3).
// A negedge monitor logs every valid word (with sot) and counts eot, frag and
// tx_ready pulses; each test task compares those logs against the words it
// sent, the framing it used and, when the transmit path is built, the miso
// bits captured at the master sample edges.
// ---------------------------------------------------------------------------
module tb_spi_slave_nbit;

  localparam int H = 8;  // SPI half period in clk cycles

`ifdef SPI_SLAVE_NBIT_TX_EN
  localparam bit TX_EN = 1'b1;
`else
  localparam bit TX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        sclk_a, ss_a, mosi_a, miso_a;
  logic [7:0]  data_a, tx_data_a;
  logic        valid_a, sot_a, eot_a, frag_a, tx_ready_a;

  logic        sclk_b, ss_b, mosi_b, miso_b;
  logic [11:0] data_b, tx_data_b;
  logic        valid_b, sot_b, eot_b, frag_b, tx_ready_b;

  spi_slave_nbit #(.WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .sclk(sclk_a), .ss(ss_a), .mosi(mosi_a),
    .miso(miso_a), .data(data_a), .valid(valid_a), .sot(sot_a),
    .eot(eot_a), .frag(frag_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a)
  );

  spi_slave_nbit #(.WIDTH(12), .CPOL(1), .CPHA(1), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst(rst), .sclk(sclk_b), .ss(ss_b), .mosi(mosi_b),
    .miso(miso_b), .data(data_b), .valid(valid_b), .sot(sot_b),
    .eot(eot_b), .frag(frag_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b)
  );

  int tests_run = 0;
  int fails     = 0;

  // Monitor logs
  logic [7:0]  va_data[$];
  bit          va_sot[$];
  logic [11:0] vb_data[$];
  bit          vb_sot[$];
  int eot_a_cnt = 0, frag_a_cnt = 0, eotfrag_a_cnt = 0, txr_a_cnt = 0;
  int eot_b_cnt = 0, frag_b_cnt = 0;
  int tx_bad_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_a) begin va_data.push_back(data_a); va_sot.push_back(sot_a); end
      if (valid_b) begin vb_data.push_back(data_b); vb_sot.push_back(sot_b); end
      if (eot_a) eot_a_cnt++;
      if (frag_a) frag_a_cnt++;
      if (eot_a && frag_a) eotfrag_a_cnt++;
      if (tx_ready_a) txr_a_cnt++;
      if (eot_b) eot_b_cnt++;
      if (frag_b) frag_b_cnt++;
      if (!TX_EN && (miso_a || tx_ready_a || miso_b || tx_ready_b)) tx_bad_cnt++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode 0 master: drive mosi while sclk low, capture miso just before rise
  task automatic a_bits(input logic [31:0] val, input int n, output logic [31:0] cap);
    cap = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi_a = val[i];
      wait_clks(H);
      cap = {cap[30:0], miso_a};
      sclk_a = 1'b1;
      wait_clks(H);
      sclk_a = 1'b0;
    end
  endtask

  task automatic a_start();
    ss_a = 1'b0;
    wait_clks(H);
  endtask

  task automatic a_stop();
    mosi_a = 1'b0;
    wait_clks(H);
    ss_a = 1'b1;
    wait_clks(2 * H);
  endtask

  // Mode 3 master: leading (falling) edge drives mosi, trailing edge samples
  task automatic b_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk_b = 1'b0;
      mosi_b = val[i];
      wait_clks(H);
      sclk_b = 1'b1;
      wait_clks(H);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(4);
    tests_run++;
    if (data_a !== 8'h00) begin
      fails++; $display("FAIL reset_data_a: got %h want 00", data_a);
    end
    tests_run++;
    if ({valid_a, sot_a, eot_a, frag_a, tx_ready_a, miso_a} !== 6'b0) begin
      fails++; $display("FAIL reset_flags_a: got %b want 000000",
                        {valid_a, sot_a, eot_a, frag_a, tx_ready_a, miso_a});
    end
    tests_run++;
    if (data_b !== 12'h000) begin
      fails++; $display("FAIL reset_data_b: got %h want 000", data_b);
    end
    tests_run++;
    if ({valid_b, sot_b, eot_b, frag_b, tx_ready_b, miso_b} !== 6'b0) begin
      fails++; $display("FAIL reset_flags_b: got %b want 000000",
                        {valid_b, sot_b, eot_b, frag_b, tx_ready_b, miso_b});
    end
    rst = 1'b0;
    wait_clks(2 * H);
    tests_run++;
    if (eot_a_cnt + eot_b_cnt + va_data.size() + vb_data.size() !== 0) begin
      fails++; $display("FAIL post_reset_quiet: got %0d events want 0",
                        eot_a_cnt + eot_b_cnt + va_data.size() + vb_data.size());
    end
  endtask

  task automatic test_two_words();
    int v0, e0, f0;
    logic [31:0] cap;
    v0 = va_data.size(); e0 = eot_a_cnt; f0 = frag_a_cnt;
    a_start();
    a_bits(32'hA5, 8, cap);
    a_bits(32'h3C, 8, cap);
    a_stop();
    tests_run++;
    if (va_data.size() - v0 !== 2) begin
      fails++; $display("FAIL two_words_count: got %0d want 2", va_data.size() - v0);
    end
    tests_run++;
    if ({va_data[v0], va_sot[v0]} !== {8'hA5, 1'b1}) begin
      fails++; $display("FAIL two_words_w0: got %h sot %0d want a5 sot 1", va_data[v0], va_sot[v0]);
    end
    tests_run++;
    if ({va_data[v0+1], va_sot[v0+1]} !== {8'h3C, 1'b0}) begin
      fails++; $display("FAIL two_words_w1: got %h sot %0d want 3c sot 0", va_data[v0+1], va_sot[v0+1]);
    end
    tests_run++;
    if ({eot_a_cnt - e0, frag_a_cnt - f0} !== {32'd1, 32'd0}) begin
      fails++; $display("FAIL two_words_eot: eot %0d frag %0d want 1 0", eot_a_cnt - e0, frag_a_cnt - f0);
    end
    tests_run++;
    if (data_a !== 8'h3C) begin
      fails++; $display("FAIL two_words_hold: got %h want 3c", data_a);
    end
  endtask

  task automatic test_miso();
    int v0, t0;
    logic [31:0] cap;
    logic [7:0]  exp_miso;
    tx_data_a = 8'h96;
    exp_miso  = TX_EN ? 8'h96 : 8'h00;
    v0 = va_data.size(); t0 = txr_a_cnt;
    a_start();
    a_bits(32'h00, 8, cap);
    a_stop();
    tests_run++;
    if (cap[7:0] !== exp_miso) begin
      fails++; $display("FAIL miso_bits: got %h want %h", cap[7:0], exp_miso);
    end
    tests_run++;
    if (txr_a_cnt - t0 !== (TX_EN ? 2 : 0)) begin
      fails++; $display("FAIL miso_tx_ready: got %0d want %0d", txr_a_cnt - t0, TX_EN ? 2 : 0);
    end
    tests_run++;
    if ({va_data.size() - v0, va_data[v0]} !== {32'd1, 8'h00}) begin
      fails++; $display("FAIL miso_rx: count %0d data %h want 1 00", va_data.size() - v0, va_data[v0]);
    end
  endtask

  task automatic test_mode3();
    int v0, e0, f0;
    v0 = vb_data.size(); e0 = eot_b_cnt; f0 = frag_b_cnt;
    ss_b = 1'b0;
    wait_clks(H);
    b_bits(32'hABC, 12);
    wait_clks(H);
    ss_b = 1'b1;
    wait_clks(2 * H);
    tests_run++;
    if (vb_data.size() - v0 !== 1) begin
      fails++; $display("FAIL mode3_count: got %0d want 1", vb_data.size() - v0);
    end
    tests_run++;
    if ({vb_data[v0], vb_sot[v0]} !== {12'hABC, 1'b1}) begin
      fails++; $display("FAIL mode3_word: got %h sot %0d want abc sot 1", vb_data[v0], vb_sot[v0]);
    end
    tests_run++;
    if ({eot_b_cnt - e0, frag_b_cnt - f0, 20'd0, data_b} !== {32'd1, 32'd0, 32'h0000_0ABC}) begin
      fails++; $display("FAIL mode3_eot: eot %0d frag %0d data %h want 1 0 abc",
                        eot_b_cnt - e0, frag_b_cnt - f0, data_b);
    end
  endtask

  task automatic test_frag();
    int v0, e0, f0, ef0;
    logic [7:0]  prev;
    logic [31:0] cap;
    prev = data_a;
    v0 = va_data.size(); e0 = eot_a_cnt; f0 = frag_a_cnt; ef0 = eotfrag_a_cnt;
    a_start();
    a_bits(32'h1B, 5, cap);
    a_stop();
    tests_run++;
    if (va_data.size() - v0 !== 0) begin
      fails++; $display("FAIL frag_no_valid: got %0d want 0", va_data.size() - v0);
    end
    tests_run++;
    if ({eot_a_cnt - e0, frag_a_cnt - f0, eotfrag_a_cnt - ef0} !== {32'd1, 32'd1, 32'd1}) begin
      fails++; $display("FAIL frag_pulses: eot %0d frag %0d same %0d want 1 1 1",
                        eot_a_cnt - e0, frag_a_cnt - f0, eotfrag_a_cnt - ef0);
    end
    tests_run++;
    if (data_a !== prev) begin
      fails++; $display("FAIL frag_hold: got %h want %h", data_a, prev);
    end
  endtask

  task automatic test_zero();
    int v0, e0, f0;
    v0 = va_data.size(); e0 = eot_a_cnt; f0 = frag_a_cnt;
    a_start();
    a_stop();
    tests_run++;
    if ({va_data.size() - v0, eot_a_cnt - e0, frag_a_cnt - f0} !== {32'd0, 32'd1, 32'd0}) begin
      fails++; $display("FAIL zero_bits: valid %0d eot %0d frag %0d want 0 1 0",
                        va_data.size() - v0, eot_a_cnt - e0, frag_a_cnt - f0);
    end
  endtask

  task automatic test_reset_abort();
    int v0, e0, f0;
    logic [31:0] cap;
    v0 = va_data.size(); e0 = eot_a_cnt; f0 = frag_a_cnt;
    a_start();
    a_bits(32'hFF, 4, cap);
    wait_clks(2);
    rst = 1'b1;
    wait_clks(4);
    tests_run++;
    if (data_a !== 8'h00) begin
      fails++; $display("FAIL abort_reset_data: got %h want 00", data_a);
    end
    rst = 1'b0;
    wait_clks(2 * H);
    a_bits(32'h12, 8, cap);
    a_stop();
    tests_run++;
    if ({va_data.size() - v0, va_data[v0], 7'd0, va_sot[v0]} !== {32'd1, 8'h12, 8'h01}) begin
      fails++; $display("FAIL abort_word: count %0d data %h sot %0d want 1 12 1",
                        va_data.size() - v0, va_data[v0], va_sot[v0]);
    end
    tests_run++;
    if ({eot_a_cnt - e0, frag_a_cnt - f0} !== {32'd1, 32'd0}) begin
      fails++; $display("FAIL abort_eot: eot %0d frag %0d want 1 0", eot_a_cnt - e0, frag_a_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    logic [31:0] cap;
    v0 = va_data.size(); e0 = eot_a_cnt;
    a_start();
    a_bits(32'h5A, 8, cap);
    wait_clks(H);
    ss_a = 1'b1;
    wait_clks(4);
    a_start();
    a_bits(32'hC3, 8, cap);
    a_stop();
    tests_run++;
    if ({va_data[v0], va_sot[v0], va_data[v0+1], va_sot[v0+1]} !== {8'h5A, 1'b1, 8'hC3, 1'b1}) begin
      fails++; $display("FAIL b2b_words: got %h/%0d %h/%0d want 5a/1 c3/1",
                        va_data[v0], va_sot[v0], va_data[v0+1], va_sot[v0+1]);
    end
    tests_run++;
    if ({va_data.size() - v0, eot_a_cnt - e0} !== {32'd2, 32'd2}) begin
      fails++; $display("FAIL b2b_counts: valid %0d eot %0d want 2 2", va_data.size() - v0, eot_a_cnt - e0);
    end
  endtask

  // Random frames: some full words plus an optional trailing fragment
  task automatic test_random_frames();
    int v0, e0, f0, t0, nw, np, nbad;
    logic [7:0]  exp_w[$];
    logic [31:0] cap, word;
    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(0, 3);
      np = $urandom_range(0, 7);
      tx_data_a = 8'($urandom);
      exp_w.delete();
      v0 = va_data.size(); e0 = eot_a_cnt; f0 = frag_a_cnt; t0 = txr_a_cnt;
      a_start();
      for (int w = 0; w < nw; w++) begin
        word = 32'($urandom_range(0, 255));
        exp_w.push_back(word[7:0]);
        a_bits(word, 8, cap);
        tests_run++;
        if (cap[7:0] !== (TX_EN ? tx_data_a : 8'h00)) begin
          fails++; $display("FAIL rand_miso f%0d w%0d: got %h want %h", f, w, cap[7:0],
                            TX_EN ? tx_data_a : 8'h00);
        end
      end
      if (np > 0) a_bits(32'($urandom), np, cap);
      a_stop();
      nbad = 0;
      for (int i = 0; i < nw; i++) begin
        if ({va_data[v0+i], va_sot[v0+i]} !== {exp_w[i], (i == 0)}) nbad++;
      end
      tests_run++;
      if (va_data.size() - v0 !== nw || nbad != 0) begin
        fails++; $display("FAIL rand_words f%0d: count %0d want %0d, %0d bad words",
                          f, va_data.size() - v0, nw, nbad);
      end
      tests_run++;
      if ({eot_a_cnt - e0, frag_a_cnt - f0} !== {32'd1, 32'(np != 0)}) begin
        fails++; $display("FAIL rand_eot f%0d: eot %0d frag %0d want 1 %0d",
                          f, eot_a_cnt - e0, frag_a_cnt - f0, np != 0);
      end
      tests_run++;
      if (txr_a_cnt - t0 !== (TX_EN ? 1 + nw : 0)) begin
        fails++; $display("FAIL rand_tx_ready f%0d: got %0d want %0d", f, txr_a_cnt - t0,
                          TX_EN ? 1 + nw : 0);
      end
    end
  endtask

  task automatic test_tx_off();
    tests_run++;
    if (tx_bad_cnt !== 0) begin
      fails++; $display("FAIL tx_off: miso/tx_ready active %0d cycles want 0", tx_bad_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    sclk_a = 1'b0; ss_a = 1'b1; mosi_a = 1'b0; tx_data_a = 8'h00;
    sclk_b = 1'b1; ss_b = 1'b1; mosi_b = 1'b0; tx_data_b = 12'h000;
    test_reset();
    test_two_words();
    test_miso();
    test_mode3();
    test_frag();
    test_zero();
    test_reset_abort();
    test_back_to_back();
    test_random_frames();
    test_tx_off();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
